// File: rtl/input_frame_segmenter.sv
`timescale 1ns/1ps
// Buffers complete input frames in a RAM ring with a descriptor FIFO. Each frame is
// replayed as SRIO payload packets, with packet-first, packet-last and frame-last markers.
module input_frame_segmenter #(
    parameter int DATA_WIDTH        = 64,
    parameter int DATA_LENGTH_WIDTH = 20,
    parameter int RAM_ADDR_WIDTH    = 10,
    parameter int MAX_PAYLOAD_BYTES = 256,
    parameter int FRAME_SLOTS       = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [DATA_WIDTH-1:0]                data_in,
    input  logic                                 data_valid_in,
    input  logic                                 data_first_in,
    input  logic [DATA_WIDTH/8-1:0]              data_keep_in,
    input  logic [DATA_LENGTH_WIDTH-1:0]         data_len_in,
    input  logic                                 data_last_in,
    output logic                                 data_ready_out,
    output logic                                 ack_o,
    output logic                                 len_err_o,
    output logic [$clog2(FRAME_SLOTS):0]         frames_stored_o,
    input  logic                                 fetch_data_in,
    input  logic                                 output_tready,
    output logic [DATA_WIDTH-1:0]                output_tdata,
    output logic                                 output_tvalid,
    output logic [DATA_WIDTH/8-1:0]              output_tkeep,
    output logic                                 output_tlast,
    output logic                                 output_pack_tfirst,
    output logic                                 output_pack_tlast
);
    localparam int KW  = DATA_WIDTH / 8;
    localparam int KSH = $clog2(KW);
    localparam int AW  = RAM_ADDR_WIDTH;
    localparam int PW  = AW + 1;
    localparam int LW  = DATA_LENGTH_WIDTH;
    localparam int SW  = $clog2(FRAME_SLOTS);
    localparam int FW  = SW + 1;
    localparam int BPP = MAX_PAYLOAD_BYTES * 8 / DATA_WIDTH;
    localparam int PKW = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int MW  = DATA_WIDTH + KW;
    localparam int EW  = MW + 3;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

    logic [MW-1:0] mem [2**AW];
    logic [PW-1:0] desc_mem [FRAME_SLOTS];
    logic [MW-1:0] ram_rdata_q;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          in_frame_q, in_frame_d;
    logic [PW-1:0] beat_cnt_q, beat_cnt_d;
    logic [LW-1:0] exp_beats_q, exp_beats_d;
    logic [FW-1:0] dwr_ptr_q, dwr_ptr_d, drd_ptr_q, drd_ptr_d;
    logic          ack_q, ack_d, len_err_q, len_err_d;
    logic [FW-1:0] frames_q, frames_d;
    state_t        state_q, state_d;
    logic [PW-1:0] rem_q, rem_d;
    logic [PKW-1:0] pk_cnt_q, pk_cnt_d;
    logic          rvalid_q, rvalid_d;
    logic [2:0]    meta_q, meta_d;
    logic [EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic          v0_q, v0_d, v1_q, v1_d;

    logic          ram_full, desc_full, wr_fire, frame_start, desc_push, len_mismatch;
    logic [PW-1:0] beats_now;
    logic [LW-1:0] exp_now;
    logic          pop_out, desc_pop, issue, issue_last;
    logic [1:0]    occ;
    logic [PW-1:0] issue_rem;
    logic [PKW-1:0] issue_pk;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign ram_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign desc_full = (dwr_ptr_q - drd_ptr_q) == FW'(FRAME_SLOTS);
    assign data_ready_out = !reset && !ram_full && (in_frame_q || !desc_full);

    always_comb begin
        wr_fire      = data_valid_in && data_ready_out;
        frame_start  = !in_frame_q;
        beats_now    = frame_start ? PW'(1) : beat_cnt_q + PW'(1);
        exp_now      = frame_start ? (data_len_in >> KSH) + LW'(1) : exp_beats_q;
        desc_push    = wr_fire && data_last_in;
        len_mismatch = 32'(beats_now) != 32'(exp_now);

        wr_ptr_d    = wr_ptr_q + PW'(wr_fire);
        in_frame_d  = wr_fire ? !data_last_in : in_frame_q;
        beat_cnt_d  = wr_fire ? beats_now : beat_cnt_q;
        exp_beats_d = wr_fire ? exp_now : exp_beats_q;
        dwr_ptr_d   = dwr_ptr_q + FW'(desc_push);
        ack_d       = desc_push;
        len_err_d   = desc_push && len_mismatch;
    end

    always_comb begin
        pop_out  = v0_q && output_tready;
        desc_pop = (state_q == S_LOAD);
        occ      = 2'(v0_q) + 2'(v1_q) + 2'(rvalid_q) - 2'(pop_out);
        // Skid entries plus the read in flight never exceed two.
        issue    = desc_pop || (state_q == S_STREAM && rem_q != '0 && occ < 2'd2);

        issue_rem  = desc_pop ? desc_mem[drd_ptr_q[SW-1:0]] : rem_q;
        issue_pk   = desc_pop ? '0 : pk_cnt_q;
        issue_last = (issue_rem == PW'(1));

        rd_ptr_d  = rd_ptr_q + PW'(issue);
        rem_d     = issue ? issue_rem - PW'(1) : rem_q;
        pk_cnt_d  = issue ? issue_pk + PKW'(1) : pk_cnt_q;
        rvalid_d  = issue;
        meta_d    = issue ? {issue_last, issue_pk == '0, (issue_pk == PKW'(BPP - 1)) || issue_last} : meta_q;
        drd_ptr_d = drd_ptr_q + FW'(desc_pop);
        frames_d  = frames_q + FW'(desc_push) - FW'(desc_pop);

        v0_d = v0_q;
        v1_d = v1_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (pop_out) begin
            v0_d   = v1_q;
            ent0_d = ent1_q;
            v1_d   = 1'b0;
        end
        if (rvalid_q) begin
            if (!v0_d) begin
                v0_d   = 1'b1;
                ent0_d = {ram_rdata_q, meta_q};
            end else begin
                v1_d   = 1'b1;
                ent1_d = {ram_rdata_q, meta_q};
            end
        end

        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fetch_data_in && frames_q != '0) state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: if (pop_out && ent0_q[2]) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= {data_keep_in, data_in};
        if (issue) ram_rdata_q <= mem[rd_ptr_q[AW-1:0]];
        if (desc_push) desc_mem[dwr_ptr_q[SW-1:0]] <= beats_now;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            in_frame_q  <= 1'b0;
            beat_cnt_q  <= '0;
            exp_beats_q <= '0;
            dwr_ptr_q   <= '0;
            drd_ptr_q   <= '0;
            ack_q       <= 1'b0;
            len_err_q   <= 1'b0;
            frames_q    <= '0;
            state_q     <= S_IDLE;
            rem_q       <= '0;
            pk_cnt_q    <= '0;
            rvalid_q    <= 1'b0;
            meta_q      <= '0;
            ent0_q      <= '0;
            ent1_q      <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            in_frame_q  <= in_frame_d;
            beat_cnt_q  <= beat_cnt_d;
            exp_beats_q <= exp_beats_d;
            dwr_ptr_q   <= dwr_ptr_d;
            drd_ptr_q   <= drd_ptr_d;
            ack_q       <= ack_d;
            len_err_q   <= len_err_d;
            frames_q    <= frames_d;
            state_q     <= state_d;
            rem_q       <= rem_d;
            pk_cnt_q    <= pk_cnt_d;
            rvalid_q    <= rvalid_d;
            meta_q      <= meta_d;
            ent0_q      <= ent0_d;
            ent1_q      <= ent1_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
        end
    end

    assign ack_o              = ack_q;
    assign len_err_o          = len_err_q;
    assign frames_stored_o    = frames_q;
    assign output_tvalid      = v0_q;
    assign output_tdata       = ent0_q[DATA_WIDTH+2:3];
    assign output_tkeep       = ent0_q[EW-1:DATA_WIDTH+3];
    assign output_tlast       = v0_q & ent0_q[2];
    assign output_pack_tfirst = v0_q & ent0_q[1];
    assign output_pack_tlast  = v0_q & ent0_q[0];

endmodule

// File: tb/tb_input_frame_segmenter.sv
`timescale 1ns/1ps
// Bench for input_frame_segmenter: a default-size instance and a 16-beat-RAM instance
// share one stimulus driver; output beats are checked against a queue-based frame model.
module tb_input_frame_segmenter;
    localparam int BPP = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic [63:0] d_data = '0;
    logic        d_valid = 1'b0, d_first = 1'b0, d_last = 1'b0;
    logic [7:0]  d_keep = '0;
    logic [19:0] d_len = '0;
    logic        fetch = 1'b0;
    logic        tready = 1'b1;

    logic        a_ready, a_ack, a_err, a_tvalid, a_tlast, a_pf, a_pl;
    logic [2:0]  a_frames;
    logic [63:0] a_tdata;
    logic [7:0]  a_tkeep;
    logic        b_ready, b_ack, b_err, b_tvalid, b_tlast, b_pf, b_pl;
    logic [2:0]  b_frames;
    logic [63:0] b_tdata;
    logic [7:0]  b_tkeep;

    input_frame_segmenter u_a (
        .clk(clk), .reset(rst), .data_in(d_data), .data_valid_in(d_valid && !sel),
        .data_first_in(d_first), .data_keep_in(d_keep), .data_len_in(d_len),
        .data_last_in(d_last), .data_ready_out(a_ready), .ack_o(a_ack), .len_err_o(a_err),
        .frames_stored_o(a_frames), .fetch_data_in(fetch), .output_tready(tready),
        .output_tdata(a_tdata), .output_tvalid(a_tvalid), .output_tkeep(a_tkeep),
        .output_tlast(a_tlast), .output_pack_tfirst(a_pf), .output_pack_tlast(a_pl)
    );

    input_frame_segmenter #(.RAM_ADDR_WIDTH(4)) u_b (
        .clk(clk), .reset(rst), .data_in(d_data), .data_valid_in(d_valid && sel),
        .data_first_in(d_first), .data_keep_in(d_keep), .data_len_in(d_len),
        .data_last_in(d_last), .data_ready_out(b_ready), .ack_o(b_ack), .len_err_o(b_err),
        .frames_stored_o(b_frames), .fetch_data_in(fetch), .output_tready(tready),
        .output_tdata(b_tdata), .output_tvalid(b_tvalid), .output_tkeep(b_tkeep),
        .output_tlast(b_tlast), .output_pack_tfirst(b_pf), .output_pack_tlast(b_pl)
    );

    wire        o_ready  = sel ? b_ready  : a_ready;
    wire        o_ack    = sel ? b_ack    : a_ack;
    wire        o_err    = sel ? b_err    : a_err;
    wire [2:0]  o_frames = sel ? b_frames : a_frames;
    wire        o_tvalid = sel ? b_tvalid : a_tvalid;
    wire [63:0] o_tdata  = sel ? b_tdata  : a_tdata;
    wire [7:0]  o_tkeep  = sel ? b_tkeep  : a_tkeep;
    wire        o_tlast  = sel ? b_tlast  : a_tlast;
    wire        o_pf     = sel ? b_pf     : a_pf;
    wire        o_pl     = sel ? b_pl     : a_pl;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        pf;
        logic        pl;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Downstream ready patterns: 0 always, 1 low 1-in-6, 2 low 1-in-4, 3 random, 4 high 1-in-4
    int tr_mode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        case (tr_mode)
            1: tready = (cyc % 6) != 0;
            2: tready = (cyc % 4) != 0;
            3: tready = 1'($urandom_range(0, 1));
            4: tready = (cyc % 4) == 0;
            default: tready = 1'b1;
        endcase
    end

    logic        out_mid = 1'b0;
    logic        stalled = 1'b0;
    logic [63:0] held = '0;
    int          out_idx = 0;

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            out_mid = 1'b0;
            stalled = 1'b0;
            out_idx = 0;
        end else begin
            if (out_mid) check_eq("tvalid_mid_frame", o_tvalid, 1);
            if (stalled && o_tvalid) check_eq("held_data", o_tdata, held);
            if (o_tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat_qdepth", 64'(exp_q.size()), 1);
                end else begin
                    b = exp_q.pop_front();
                    check_eq("tdata", o_tdata, b.data);
                    check_eq("keep_last_pf_pl", {o_tkeep, o_tlast, o_pf, o_pl},
                             {b.keep, b.last, b.pf, b.pl});
                    out_mid = !o_tlast;
                    out_idx = o_tlast ? 0 : out_idx + 1;
                end
            end
            stalled = o_tvalid && !tready;
            held    = o_tdata;
        end
    end

    task automatic send_frame(input int n, input logic [63:0] base, input logic [7:0] fkeep,
                              input int len, input bit rnd, output int stalls);
        int    t;
        bit    acc;
        beat_t b;
        logic [7:0] k;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            k = (i == 0) ? fkeep : (rnd ? 8'($urandom_range(1, 255)) : 8'hff);
            b.data = base + 64'(i);
            b.keep = k;
            b.last = (i == n - 1);
            b.pf   = (i % BPP) == 0;
            b.pl   = ((i % BPP) == BPP - 1) || (i == n - 1);
            exp_q.push_back(b);
            d_valid = 1'b1;
            d_data  = b.data;
            d_keep  = k;
            d_first = (i == 0) || (rnd && $urandom_range(0, 7) == 0);
            d_last  = (i == n - 1);
            d_len   = (i == 0) ? 20'(len) : 20'($urandom);
            t = 0;
            do begin
                @(negedge clk);
                acc = o_ready;
                if (!acc) stalls++;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 3000);
            if (!acc) begin
                check_eq("write_accept_timeout", 64'(acc), 1);
                d_valid = 1'b0;
                return;
            end
        end
        d_valid = 1'b0;
        d_first = 1'b0;
        d_last  = 1'b0;
        check_eq("ack", o_ack, 1);
        check_eq("len_err", o_err, 64'((len / 8 + 1) != n));
        @(posedge clk);
        #1;
        check_eq("ack_single_pulse", o_ack, 0);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || o_tvalid) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_eq(tag, 64'(exp_q.size()), 0);
        check_eq("frames_after_drain", o_frames, 0);
    endtask

    initial begin
        int st;
        int n, len, t;
        #38 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_tvalid", o_tvalid, 0);
        check_eq("rst_frames", o_frames, 0);
        check_eq("rst_ack", o_ack, 0);
        check_eq("rst_ready", o_ready, 1);

        // 33-beat frame, first keep 0xf0, replay enabled at 550 ns
        @(posedge clk); #1;
        send_frame(33, 64'hff, 8'hf0, 263, 1'b0, st);
        check_eq("t1_frames_stored", o_frames, 1);
        check_eq("t1_no_output_before_fetch", o_tvalid, 0);
        while ($time < 550) @(posedge clk);
        #1 fetch = 1'b1;
        drain("t1_drain");

        tr_mode = 1;
        send_frame(33, 64'hff, 8'hf0, 263, 1'b0, st);
        drain("t2_drain_6");
        tr_mode = 2;
        send_frame(33, 64'hff, 8'hf0, 263, 1'b0, st);
        drain("t2_drain_4");
        tr_mode = 0;

        // Fill all descriptor slots, then release them back to back
        fetch = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(8, 64'h1000 * (f + 1), 8'hff, 63, 1'b0, st);
        check_eq("t3_frames_full", o_frames, 4);
        @(negedge clk);
        check_eq("t3_ready_low_slots_full", o_ready, 0);
        @(posedge clk); #1;
        fetch = 1'b1;
        send_frame(8, 64'h5000, 8'hff, 63, 1'b0, st);
        check_eq("t3_fifth_frame_stalled", 64'(st > 0), 1);
        drain("t3_drain");

        send_frame(20, 64'h7700, 8'hff, 255, 1'b0, st);
        drain("t4_drain");

        // Small 16-beat RAM: second frame written while the first replays
        sel = 1'b1;
        tr_mode = 4;
        for (int r = 0; r < 3; r++) begin
            send_frame(12, 64'h9000 + 64'(r * 64), 8'h0f, 95, 1'b1, st);
            send_frame(12, 64'hA000 + 64'(r * 64), 8'h3c, 95, 1'b1, st);
            check_eq("t5_write_stalled_full", 64'(st > 0), 1);
        end
        drain("t5_drain");
        sel = 1'b0;

        tr_mode = 3;
        for (int f = 0; f < 12; f++) begin
            n   = $urandom_range(1, 40);
            len = ($urandom_range(0, 3) != 0) ? (n - 1) * 8 + $urandom_range(0, 7)
                                              : $urandom_range(0, 400);
            send_frame(n, {$urandom, $urandom}, 8'($urandom_range(1, 255)), len, 1'b1, st);
        end
        drain("t6_drain");

        // Reset while beat 10 of a frame is streaming
        tr_mode = 0;
        send_frame(33, 64'hC000, 8'hff, 263, 1'b0, st);
        t = 0;
        while (out_idx < 10 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq("t7_reached_beat10", 64'(out_idx >= 10), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t7_rst_tvalid", o_tvalid, 0);
        check_eq("t7_rst_flags", {o_tlast, o_pf, o_pl, o_ack, o_err, o_ready}, 0);
        check_eq("t7_rst_tdata", o_tdata, 0);
        check_eq("t7_rst_tkeep", o_tkeep, 0);
        check_eq("t7_rst_frames", o_frames, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send_frame(17, 64'hD000, 8'h81, 135, 1'b0, st);
        drain("t7_drain_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/input_frame_segmenter.md
Name: input_frame_segmenter

Overview:
- Multi-frame successor of the input reader.
- Buffers up to FRAME_SLOTS complete AXI-stream-style frames in an internal RAM ring, with a descriptor FIFO alongside.
- On request, replays each frame as a sequence of SRIO payload packets of at most MAX_PAYLOAD_BYTES, with packet-first/packet-last markers.
- Sits between the user data source and the SRIO request generator in the log_clk domain.

Parameters:
- DATA_WIDTH, 64: data bus width in bits; a multiple of 8, power of 2.
- DATA_LENGTH_WIDTH, 20: width of the frame byte-length field.
- RAM_ADDR_WIDTH, 10: data RAM depth is 2^RAM_ADDR_WIDTH beats.
- MAX_PAYLOAD_BYTES, 256: packet size in bytes; a multiple of DATA_WIDTH/8 and a power of 2.
- FRAME_SLOTS, 4: maximum frames held at once; a power of 2.

Ports:
- clk  in  1  log_clk.
- reset  in  1  asynchronous, active-high.
- data_in  in  DATA_WIDTH  write data.
- data_valid_in  in  1  write beat valid.
- data_first_in  in  1  first beat of frame.
- data_keep_in  in  DATA_WIDTH/8  byte enables, stored per beat.
- data_len_in  in  DATA_LENGTH_WIDTH  frame bytes minus 1; sampled on the first beat.
- data_last_in  in  1  last beat of frame.
- data_ready_out  out  1  write beat accepted when valid && ready.
- ack_o  out  1  one-cycle pulse: frame fully stored.
- len_err_o  out  1  one-cycle pulse with ack_o: beat count differs from declared length.
- frames_stored_o  out  $clog2(FRAME_SLOTS)+1  committed frames not yet read out.
- fetch_data_in  in  1  level: permission to start reading out the next frame.
- output_tready  in  1  downstream ready.
- output_tdata  out  DATA_WIDTH  read data.
- output_tvalid  out  1  read beat valid.
- output_tkeep  out  DATA_WIDTH/8  stored byte enables.
- output_tlast  out  1  last beat of frame.
- output_pack_tfirst  out  1  first beat of packet.
- output_pack_tlast  out  1  last beat of packet.

Behaviour:
- Reset: all outputs 0, frames_stored_o 0; pointers, descriptor FIFO, beat counters and FSMs cleared. Reset mid-frame discards every stored and partially written or read frame. The first accepted beat after reset must carry data_first_in.
- Write side:
  - data_ready_out = RAM not full AND (a beat within a frame OR a free descriptor slot).
  - A beat is written to RAM (data + keep) on valid && ready. data_valid_in while ready is low: the beat is not taken; the source holds it.
  - The first beat latches data_len_in. A beat counter increments per beat.
  - On the last beat the descriptor {beat_count} is pushed. Next cycle: ack_o=1, and frames_stored_o increments.
  - len_err_o=1 with ack_o when beat_count != data_len_in/(DATA_WIDTH/8)+1. The frame is still stored with its actual beat count.
  - data_first_in mid-frame: ignored as a marker; the beat is stored as data.
  - A frame longer than 2^RAM_ADDR_WIDTH beats is illegal.
- Read FSM states:
  - IDLE -> LOAD when fetch_data_in && frames_stored_o != 0.
  - LOAD: pop descriptor, issue the first RAM read; 1-cycle registered read latency.
  - STREAM: 2-entry skid buffer, so output_tvalid stays high and data is held stable while output_tready is low. No bubbles when tready is continuously high.
  - STREAM -> IDLE after the tlast beat transfers.
- fetch_data_in is sampled only in IDLE. Dropping it mid-frame does not stop the current frame.
- Packetisation, with BPP = MAX_PAYLOAD_BYTES*8/DATA_WIDTH:
  - The packet beat counter resets at frame start.
  - output_pack_tfirst on beat index 0 of each packet.
  - output_pack_tlast when packet beat index == BPP-1 or on the frame's last beat.
  - output_tlast only on the frame's last beat.
  - A single-beat packet asserts pack_tfirst and pack_tlast together.
- frames_stored_o decrements when the descriptor is popped in LOAD. The freed RAM space is released as beats are read.
- Simultaneous ack increment and LOAD decrement in the same cycle: net 0.
- Pointers wrap modulo 2^RAM_ADDR_WIDTH. Full/empty is tracked with an extra pointer MSB.
- Writes and reads proceed concurrently, including on the same frame slot ring.

Test Plan:
- Reset 38 ns. One frame of 33 beats: data 0xff..0x11f, first keep 0xf0, data_len_in=263, fetch at 550 ns.
  - -> ack_o once, len_err_o=0.
  - -> packet 1 is beats 0-31 with pack_tfirst@0 and pack_tlast@31.
  - -> packet 2 is beat 32 alone, with pack_tfirst=pack_tlast=tlast=1 and tkeep 0xff.
  - -> first output tkeep is 0xf0.
- Same frame with output_tready toggled low 1 cycle every 6, then every 4 cycles.
  - -> no beat lost or duplicated; tdata sequence 0xff..0x11f intact.
  - -> tvalid never drops mid-frame.
- Four 8-beat frames written with fetch_data_in=0.
  - -> frames_stored_o=4, data_ready_out=0 when a fifth first beat is offered.
  - -> raise fetch: four back-to-back frames, each a single packet with tlast; ready returns after the first LOAD.
- 20-beat frame declared as data_len_in=255.
  - -> len_err_o pulse with ack_o; the 20 beats are replayed with tlast on beat 19.
- RAM_ADDR_WIDTH=4, a 12-beat frame, then a 12-beat frame while the first is reading.
  - -> write stalls at full, pointer wrap is correct, and the second frame's data is intact.
- Assert reset during beat 10 of a streaming frame.
  - -> all outputs 0 within the same cycle, frames_stored_o=0.
  - -> a subsequent frame replays correctly.
